// File: rtl/npc_pipe_if.sv
// npc_pipe_if: redirect bundle from execute plus fetch PC outputs.
// master = execute/frontend side, slave = npc_pipe.
interface npc_pipe_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [1:0]      redirect_op;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] redirect_offset;
  logic [XLEN-1:0] redirect_alu_c;
  logic [XLEN-1:0] redirect_pred;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic            pc_valid;
  logic            flush;
  logic            misalign;

  modport master (
    output stall, redirect_valid, redirect_op,
    output redirect_pc, redirect_offset,
    output redirect_alu_c, redirect_pred,
    input  pc, pc4, pc_valid, flush, misalign
  );

  modport slave (
    input  stall, redirect_valid, redirect_op,
    input  redirect_pc, redirect_offset,
    input  redirect_alu_c, redirect_pred,
    output pc, pc4, pc_valid, flush, misalign
  );
endinterface

// File: rtl/npc_pipe.sv
// npc_pipe: fetch PC register, redirect/flush and misalign halt.
// Optional direct-mapped BTB enabled by defining NPC_BTB_EN.
module npc_pipe #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BTB_DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  npc_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic            misalign_q;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] rpc4;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] nxt;
  logic            run;
  logic            mispredict;
  logic            bad;

  // alu_c bit 0 is always cleared for jalr targets
  logic unused_alu0;
  assign unused_alu0 = bus.redirect_alu_c[0];

  assign pc4  = pc_q + FOUR;
  assign rpc4 = bus.redirect_pc + FOUR;

  // resolved control-transfer target
  always_comb begin
    target = rpc4;
    case (bus.redirect_op)
      2'b01:   target = bus.redirect_pc
                      + bus.redirect_offset;
      2'b10:   target = {bus.redirect_alu_c[XLEN-1:1],
                         1'b0};
      default: target = rpc4;
    endcase
  end

  assign run        = (state_q == RUN);
  assign mispredict = bus.redirect_valid & run
                    & (target != bus.redirect_pred);
  assign bad        = mispredict & (target[1:0] != 2'b00);

`ifdef NPC_BTB_EN
  localparam int IW = $clog2(BTB_DEPTH);
  localparam int TW = XLEN - IW - 2;

  logic [BTB_DEPTH-1:0] bv_q;
  logic [TW-1:0]        btag_q [BTB_DEPTH];
  logic [XLEN-1:0]      btgt_q [BTB_DEPTH];

  logic [IW-1:0] li;
  logic [IW-1:0] wi;
  logic [TW-1:0] lt;
  logic [TW-1:0] wt;
  logic          hit;
  logic          upd;
  logic          taken;

  assign li    = pc_q[IW+1:2];
  assign lt    = pc_q[XLEN-1:IW+2];
  assign wi    = bus.redirect_pc[IW+1:2];
  assign wt    = bus.redirect_pc[XLEN-1:IW+2];
  assign hit   = bv_q[li] && (btag_q[li] == lt);
  assign nxt   = hit ? btgt_q[li] : pc4;
  assign upd   = bus.redirect_valid & run & ~bad;
  assign taken = (target != rpc4);

  // BTB valid bits: set on taken resolve, drop on not-taken match
  always_ff @(posedge clk) begin
    if (rst) begin
      bv_q <= '0;
    end else if (upd) begin
      if (taken)
        bv_q[wi] <= 1'b1;
      else if (btag_q[wi] == wt)
        bv_q[wi] <= 1'b0;
    end
  end

  // BTB payload, qualified by the valid bits so never reset
  always_ff @(posedge clk) begin
    if (upd && taken) begin
      btag_q[wi] <= wt;
      btgt_q[wi] <= target;
    end
  end
`else
  assign nxt = pc4;
`endif

  // control FSM with registered pc, pc_valid and misalign
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (bad) begin
            state_q    <= HALT;
            valid_q    <= 1'b0;
            misalign_q <= 1'b1;
          end else if (mispredict) begin
            pc_q <= target;
          end else if (!bus.stall) begin
            pc_q <= nxt;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc4      = pc4;
  assign bus.pc_valid = valid_q;
  assign bus.misalign = misalign_q;
  assign bus.flush    = mispredict & ~rst;

endmodule
